sudoku_grid_checker: RTL and testbench

Parametrised Sudoku grid store and validator for the Tiny Tapeout Sudoku design; the successor to the single-size, rows-only checker. Holds an N²×N² grid (N = box size) loaded serially, then scans rows, columns and boxes one cell per clock. Flags duplicates and out-of-range values, reports the first error's location, and reports a solved grid. Sits between the pin-level wrapper (ui_in/uo_out mapping) and the grid-input path.

---
 rtl/sudoku_pkg.sv | 38 +++
 rtl/sudoku_group_tracker.sv | 39 +++
 rtl/sudoku_grid_checker.sv | 183 ++++++++++++++++++
 tb/tb_sudoku_grid_checker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sudoku_pkg.sv
// Shared encodings and elaboration-time helpers for the Sudoku grid checker.
package sudoku_pkg;

  localparam logic [1:0] ERR_RANGE = 2'd0;
  localparam logic [1:0] ERR_ROW   = 2'd1;
  localparam logic [1:0] ERR_COL   = 2'd2;
  localparam logic [1:0] ERR_BOX   = 2'd3;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_ROWS  = 2'd1,
    PH_COLS  = 2'd2,
    PH_BOXES = 2'd3
  } phase_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned side(input int unsigned box);
    return box * box;
  endfunction

  // Duplicate kind reported by each scan phase.
  function automatic logic [1:0] phase_kind(input phase_t p);
    case (p)
      PH_COLS:  return ERR_COL;
      PH_BOXES: return ERR_BOX;
      default:  return ERR_ROW;
    endcase
  endfunction

endpackage

// File: rtl/sudoku_group_tracker.sv
// Seen-digit mask for one row/column/box; flags duplicates and out-of-range values.
module sudoku_group_tracker
  import sudoku_pkg::*;
#(
  parameter int unsigned S  = 9,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mark,
  input  logic          first,
  input  logic [VW-1:0] value,
  output logic          dup_c,
  output logic          range_c
);

  logic [S-1:0] mask;
  logic [S-1:0] base_c;
  logic [S-1:0] onehot_c;
  logic         in_range_c;

  // The first cell of a group sees an empty mask regardless of stale contents.
  always_comb begin
    base_c     = first ? '0 : mask;
    in_range_c = (value != '0) && (value <= VW'(S));
    onehot_c   = in_range_c ? (S'(1) << (value - VW'(1))) : '0;
    dup_c      = |(base_c & onehot_c);
    range_c    = value > VW'(S);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (mark) begin
      mask <= base_c | onehot_c;
    end
  end

endmodule

// File: rtl/sudoku_grid_checker.sv
// Serially loaded Sudoku grid with a one-cell-per-clock row/column/box validator.
module sudoku_grid_checker
  import sudoku_pkg::*;
#(
  parameter int unsigned BOX         = 3,
  parameter bit          STOP_ON_ERR = 1'b1,
  localparam int unsigned S  = side(BOX),
  localparam int unsigned VW = clog2(S + 1),
  localparam int unsigned IW = clog2(S)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [VW-1:0] load_value,
  input  logic          load_clear,
  output logic          load_ready,
  input  logic          check_start,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          solved,
  output logic [1:0]    err_kind,
  output logic [IW-1:0] err_group,
  output logic [VW-1:0] err_value
);

  localparam int unsigned CELLS = S * S;
  localparam int unsigned AW    = clog2(CELLS);

  logic [VW-1:0] grid [CELLS];
  logic [IW-1:0] ld_row, ld_col;
  logic          ready_q;
  logic          full_q;
  phase_t        phase;
  logic [IW-1:0] grp, idx, box_r, box_c, in_r, in_c;

  logic          accept_c, scanning_c, first_c, last_cell_c, last_grp_c;
  logic          dup_c, range_c, range_hit_c, hit_c, finish_c;
  logic [1:0]    kind_c;
  logic [IW-1:0] scan_row_c, scan_col_c;
  logic [AW-1:0] ld_addr_c, scan_addr_c;
  logic [VW-1:0] cell_c;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v, input int unsigned lim);
    return (v == IW'(lim - 1)) ? '0 : v + IW'(1);
  endfunction

  assign load_ready = ready_q & ~busy & ~check_start;
  assign accept_c   = load_valid & load_ready;

  // Map the current phase/counters onto a grid coordinate.
  always_comb begin
    scan_row_c = grp;
    scan_col_c = idx;
    case (phase)
      PH_COLS: begin
        scan_row_c = idx;
        scan_col_c = grp;
      end
      PH_BOXES: begin
        scan_row_c = IW'(box_r * BOX + in_r);
        scan_col_c = IW'(box_c * BOX + in_c);
      end
      default: ;
    endcase
  end

  assign ld_addr_c   = AW'(ld_row) * AW'(S) + AW'(ld_col);
  assign scan_addr_c = AW'(scan_row_c) * AW'(S) + AW'(scan_col_c);
  assign cell_c      = grid[scan_addr_c];

  assign scanning_c  = (phase != PH_IDLE);
  assign first_c     = (idx == '0);
  assign last_cell_c = (idx == IW'(S - 1));
  assign last_grp_c  = (grp == IW'(S - 1));
  assign range_hit_c = (phase == PH_ROWS) && range_c;
  assign hit_c       = scanning_c && (range_hit_c || dup_c);
  assign kind_c      = range_hit_c ? ERR_RANGE : phase_kind(phase);
  assign finish_c    = (hit_c && STOP_ON_ERR) ||
                       ((phase == PH_BOXES) && last_cell_c && last_grp_c);

  sudoku_group_tracker #(.S(S), .VW(VW)) u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .mark    (scanning_c),
    .first   (first_c),
    .value   (cell_c),
    .dup_c   (dup_c),
    .range_c (range_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CELLS; i++) grid[i] <= '0;
    end else if (accept_c) begin
      grid[ld_addr_c] <= load_value;
    end
  end

  // Clear wins over an advance; the write itself still uses the old pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_row <= '0;
      ld_col <= '0;
    end else if (load_clear) begin
      ld_row <= '0;
      ld_col <= '0;
    end else if (accept_c) begin
      ld_col <= wrap_inc(ld_col, S);
      if (ld_col == IW'(S - 1)) ld_row <= wrap_inc(ld_row, S);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= PH_IDLE;
      ready_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      solved    <= 1'b0;
      full_q    <= 1'b0;
      err_kind  <= '0;
      err_group <= '0;
      err_value <= '0;
      grp       <= '0;
      idx       <= '0;
      box_r     <= '0;
      box_c     <= '0;
      in_r      <= '0;
      in_c      <= '0;
    end else begin
      ready_q <= 1'b1;
      if (phase == PH_IDLE) begin
        if (check_start) begin
          phase     <= PH_ROWS;
          busy      <= 1'b1;
          done      <= 1'b0;
          error     <= 1'b0;
          solved    <= 1'b0;
          full_q    <= 1'b1;
          err_kind  <= '0;
          err_group <= '0;
          err_value <= '0;
          grp       <= '0;
          idx       <= '0;
          box_r     <= '0;
          box_c     <= '0;
          in_r      <= '0;
          in_c      <= '0;
        end
      end else begin
        if ((phase == PH_ROWS) && (cell_c == '0)) full_q <= 1'b0;
        if (hit_c) begin
          error <= 1'b1;
          if (!error) begin
            err_kind  <= kind_c;
            err_group <= grp;
            err_value <= cell_c;
          end
        end
        if (finish_c) begin
          phase  <= PH_IDLE;
          busy   <= 1'b0;
          done   <= 1'b1;
          solved <= full_q & ~error & ~hit_c;
        end else begin
          // Box sub-counters run in every phase and realign to zero at each phase boundary.
          idx  <= wrap_inc(idx, S);
          in_c <= wrap_inc(in_c, BOX);
          if (in_c == IW'(BOX - 1)) in_r <= wrap_inc(in_r, BOX);
          if (last_cell_c) begin
            grp   <= wrap_inc(grp, S);
            box_c <= wrap_inc(box_c, BOX);
            if (box_c == IW'(BOX - 1)) box_r <= wrap_inc(box_r, BOX);
            if (last_grp_c) phase <= (phase == PH_ROWS) ? PH_COLS : PH_BOXES;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sudoku_grid_checker.sv
// Randomized and directed bench for sudoku_grid_checker against a grid-level reference model.
module tb_sudoku_grid_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic       lv, lc, cs;
  logic [4:0] lval;

  logic       a_ready, a_busy, a_done, a_error, a_solved;
  logic [1:0] a_kind;
  logic [3:0] a_group;
  logic [3:0] a_value;
  logic       b_ready, b_busy, b_done, b_error, b_solved;
  logic [1:0] b_kind;
  logic [1:0] b_group;
  logic [2:0] b_value;

  sudoku_grid_checker #(.BOX(3), .STOP_ON_ERR(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .load_valid(lv & ~sel), .load_value(lval[3:0]), .load_clear(lc & ~sel),
    .load_ready(a_ready), .check_start(cs & ~sel),
    .busy(a_busy), .done(a_done), .error(a_error), .solved(a_solved),
    .err_kind(a_kind), .err_group(a_group), .err_value(a_value)
  );

  sudoku_grid_checker #(.BOX(2), .STOP_ON_ERR(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .load_valid(lv & sel), .load_value(lval[2:0]), .load_clear(lc & sel),
    .load_ready(b_ready), .check_start(cs & sel),
    .busy(b_busy), .done(b_done), .error(b_error), .solved(b_solved),
    .err_kind(b_kind), .err_group(b_group), .err_value(b_value)
  );

  logic       m_ready, m_busy, m_done, m_error, m_solved;
  logic [1:0] m_kind;
  logic [3:0] m_group;
  logic [4:0] m_value;
  assign m_ready  = sel ? b_ready  : a_ready;
  assign m_busy   = sel ? b_busy   : a_busy;
  assign m_done   = sel ? b_done   : a_done;
  assign m_error  = sel ? b_error  : a_error;
  assign m_solved = sel ? b_solved : a_solved;
  assign m_kind   = sel ? b_kind   : a_kind;
  assign m_group  = sel ? {2'b00, b_group} : a_group;
  assign m_value  = sel ? {2'b00, b_value} : {1'b0, a_value};

  int n_checks = 0;
  int n_pass   = 0;
  int g[16][16];
  int perm[17];
  int e_len, e_err, e_kind, e_group, e_value, e_solved;
  int obs_len;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic ident_perm();
    for (int i = 0; i < 17; i++) perm[i] = i;
  endtask

  task automatic swap_perm(input int a, input int b);
    int t;
    t = perm[a]; perm[a] = perm[b]; perm[b] = t;
  endtask

  task automatic shuffle_perm(input int s);
    for (int i = s; i >= 2; i--) swap_perm(i, int'($urandom_range(1, i)));
  endtask

  // Canonical valid Sudoku pattern with digits relabelled through perm.
  task automatic set_base(input int bx);
    int s;
    s = bx * bx;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        g[r][c] = (r < s && c < s) ? perm[(bx * (r % bx) + r / bx + c) % s + 1] : 0;
  endtask

  task automatic clear_grid();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) g[r][c] = 0;
  endtask

  // Reference: walk rows, columns, boxes in scan order applying the checking rules.
  task automatic model(input int bx, input bit stop);
    int s, n, v, r, c, k;
    bit bad, zero;
    bit seen[17];
    s = bx * bx; n = 0; zero = 0; r = 0; c = 0;
    e_len = 3 * s * s; e_err = 0; e_kind = 0; e_group = 0; e_value = 0; e_solved = 0;
    for (int ph = 0; ph < 3; ph++) begin
      for (int grp = 0; grp < s; grp++) begin
        for (int d = 0; d < 17; d++) seen[d] = 0;
        for (int i = 0; i < s; i++) begin
          case (ph)
            0:       begin r = grp; c = i; end
            1:       begin r = i; c = grp; end
            default: begin r = (grp / bx) * bx + i / bx; c = (grp % bx) * bx + i % bx; end
          endcase
          v = g[r][c]; n++; bad = 0; k = 0;
          if (v == 0) begin
            if (ph == 0) zero = 1;
          end else if (v > s) begin
            if (ph == 0) bad = 1;
          end else if (seen[v]) begin
            bad = 1; k = ph + 1;
          end else begin
            seen[v] = 1;
          end
          if (bad && e_err == 0) begin
            e_err = 1; e_kind = k; e_group = grp; e_value = v;
            if (stop) begin
              e_len = n;
              return;
            end
          end
        end
      end
    end
    e_solved = (e_err == 0 && !zero) ? 1 : 0;
  endtask

  task automatic load_grid(input int s);
    lc = 1'b1; lv = 1'b0;
    @(negedge clk);
    lc = 1'b0;
    for (int r = 0; r < s; r++)
      for (int c = 0; c < s; c++) begin
        lv = 1'b1; lval = 5'(g[r][c]);
        @(negedge clk);
      end
    lv = 1'b0;
  endtask

  // Start a scan, check every busy cycle, then compare the final result with the model.
  task automatic run_scan(input bit hold_load);
    int cnt;
    cnt = 0;
    cs = 1'b1;
    if (hold_load) begin
      lv = 1'b1; lval = 5'd1;
      #1;
      check("ready_on_start", int'(m_ready), 0);
    end
    @(negedge clk);
    cs = 1'b0;
    while (m_busy && cnt < 2000) begin
      cnt++;
      check("ready_while_busy", int'(m_ready), 0);
      check("done_while_busy", int'(m_done), 0);
      @(negedge clk);
    end
    lv = 1'b0;
    obs_len = cnt;
    check("scan_len", cnt, e_len);
    check("done", int'(m_done), 1);
    check("error", int'(m_error), e_err);
    check("solved", int'(m_solved), e_solved);
    check("err_kind", int'(m_kind), e_kind);
    check("err_group", int'(m_group), e_group);
    check("err_value", int'(m_value), e_value);
  endtask

  initial begin
    sel = 1'b0; lv = 1'b0; lc = 1'b0; cs = 1'b0; lval = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check("reset_a", int'({a_ready, a_busy, a_done, a_error, a_solved, a_kind, a_group, a_value}), 0);
    check("reset_b", int'({b_ready, b_busy, b_done, b_error, b_solved, b_kind, b_group, b_value}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset_a", int'(a_ready), 1);
    check("ready_after_reset_b", int'(b_ready), 1);

    // Clean solved grid.
    ident_perm(); set_base(3); model(3, 1'b1);
    load_grid(9); run_scan(1'b0);
    check("clean_len_lit", obs_len, 243);
    check("clean_solved_lit", int'(m_solved), 1);

    // One empty cell: valid but unsolved.
    g[4][4] = 0; model(3, 1'b1);
    load_grid(9); run_scan(1'b0);
    check("empty_len_lit", obs_len, 243);
    check("empty_solved_lit", int'(m_solved), 0);
    check("empty_error_lit", int'(m_error), 0);

    // Row duplicate of 7 at (2,1) and (2,5).
    ident_perm(); swap_perm(7, 8); set_base(3); g[2][5] = 7; model(3, 1'b1);
    load_grid(9); run_scan(1'b0);
    check("rowdup_len_lit", obs_len, 24);
    check("rowdup_kind_lit", int'(m_kind), 1);
    check("rowdup_group_lit", int'(m_group), 2);
    check("rowdup_value_lit", int'(m_value), 7);

    // Result is sticky across a load; then a scan with load_valid held writes nothing.
    set_base(3); load_grid(9);
    check("sticky_done", int'(m_done), 1);
    check("sticky_error", int'(m_error), 1);
    check("sticky_group", int'(m_group), 2);
    model(3, 1'b1); run_scan(1'b1);
    check("hold_solved_lit", int'(m_solved), 1);

    // Column-only duplicate of 5 in column 3 (rows 0 and 6).
    ident_perm(); swap_perm(5, 6); set_base(3);
    begin
      int t;
      t = g[0][3]; g[0][3] = g[0][5]; g[0][5] = t;
    end
    model(3, 1'b1); load_grid(9); run_scan(1'b0);
    check("coldup_kind_lit", int'(m_kind), 2);
    check("coldup_group_lit", int'(m_group), 3);
    check("coldup_value_lit", int'(m_value), 5);
    check("coldup_len_lit", obs_len, 115);

    // Out-of-range value at (0,0).
    ident_perm(); set_base(3); g[0][0] = 10; model(3, 1'b1);
    load_grid(9); run_scan(1'b0);
    check("range_len_lit", obs_len, 1);
    check("range_kind_lit", int'(m_kind), 0);
    check("range_value_lit", int'(m_value), 10);

    // load_clear together with a write: write lands on cell 3, pointer returns to 0.
    ident_perm(); set_base(3); load_grid(9);
    for (int i = 0; i < 3; i++) begin
      lv = 1'b1; lval = 5'd9;
      @(negedge clk);
    end
    lc = 1'b1; lv = 1'b1; lval = 5'd1;
    @(negedge clk);
    lc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lval = 5'(g[0][i]);
      @(negedge clk);
    end
    lv = 1'b0;
    g[0][3] = 1; model(3, 1'b1); run_scan(1'b0);
    check("clear_len_lit", obs_len, 4);
    check("clear_value_lit", int'(m_value), 1);

    // BOX=2, run-to-completion: box-only duplicate in box 1.
    sel = 1'b1;
    clear_grid(); g[0][0] = 1; g[0][1] = 2; g[0][2] = 3; g[1][3] = 3;
    model(2, 1'b0); load_grid(4); run_scan(1'b0);
    check("boxdup_len_lit", obs_len, 48);
    check("boxdup_kind_lit", int'(m_kind), 3);
    check("boxdup_group_lit", int'(m_group), 1);

    // Range error first; later row/box duplicates leave err_* unchanged.
    clear_grid(); g[0][0] = 5; g[1][0] = 2; g[1][1] = 2;
    model(2, 1'b0); load_grid(4); run_scan(1'b0);
    check("keepfirst_kind_lit", int'(m_kind), 0);
    check("keepfirst_value_lit", int'(m_value), 5);
    check("keepfirst_error_lit", int'(m_error), 1);

    // Randomized grids with a few corrupted cells on both instances.
    for (int t = 0; t < 24; t++) begin
      int bx, s, ncor;
      sel = (t % 2 == 1);
      bx = sel ? 2 : 3;
      s = bx * bx;
      ident_perm(); shuffle_perm(s); set_base(bx);
      ncor = int'($urandom_range(0, 2));
      for (int j = 0; j < ncor; j++)
        g[$urandom_range(0, s - 1)][$urandom_range(0, s - 1)] =
          sel ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 11));
      model(bx, ~sel);
      load_grid(s);
      run_scan(t % 3 == 0);
    end

    // Asynchronous reset in the middle of a scan clears state and the grid.
    sel = 1'b0;
    ident_perm(); set_base(3); load_grid(9);
    cs = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    repeat (10) @(negedge clk);
    check("midscan_busy", int'(a_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", int'(a_busy), 0);
    check("async_done", int'(a_done), 0);
    check("async_ready", int'(a_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", int'(a_ready), 1);
    clear_grid(); model(3, 1'b1); run_scan(1'b0);
    check("cleared_solved_lit", int'(m_solved), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
